// File: rtl/fix_reg_bank_if.sv
// Control-channel register bus between the SPI front end (master) and fix_reg_bank (slave).
interface fix_reg_bank_if #(
    parameter int SPI_ADDR_LENGTH = 16,
    parameter int SHORT_REG_WD    = 16
);
    logic                       i_rd_en;
    logic                       i_wr_en;
    logic [SPI_ADDR_LENGTH-1:0] iv_addr;
    logic [SHORT_REG_WD-1:0]    iv_wr_data;
    logic                       o_fix_sel;
    logic [SHORT_REG_WD-1:0]    ov_fix_rd_data;

    modport master (
        output i_rd_en, i_wr_en, iv_addr, iv_wr_data,
        input  o_fix_sel, ov_fix_rd_data
    );

    modport slave (
        input  i_rd_en, i_wr_en, iv_addr, iv_wr_data,
        output o_fix_sel, ov_fix_rd_data
    );
endinterface

// File: rtl/fix_reg_bank.sv
// Identity/scratch/read-counter register bank with a registered read port on clk_sample.
// Define FIX_UPTIME_CNT_EN to build the 64-bit uptime counter with snapshot at 0x08-0x0B.
module fix_reg_bank #(
    parameter int                     SPI_ADDR_LENGTH = 16,
    parameter int                     SHORT_REG_WD    = 16,
    parameter int                     LONG_REG_WD     = 64,
    parameter int                     DEC_WD          = 9,
    parameter logic [SHORT_REG_WD-1:0] VENDOR_ID      = 16'h4448,
    parameter logic [SHORT_REG_WD-1:0] PRODUCT_ID     = 16'h0182,
    parameter logic [SHORT_REG_WD-1:0] FPGA_VERSION_H = 16'h0102,
    parameter logic [SHORT_REG_WD-1:0] FPGA_VERSION_L = 16'h0202,
    parameter logic [SHORT_REG_WD-1:0] TEST_VERSION   = 16'h2000
) (
    input logic           clk_sample,
    input logic           reset_sample,
    fix_reg_bank_if.slave bus
);

    localparam logic [DEC_WD-1:0] ADDR_VENDOR  = DEC_WD'(0);
    localparam logic [DEC_WD-1:0] ADDR_PRODUCT = DEC_WD'(1);
    localparam logic [DEC_WD-1:0] ADDR_VER_H   = DEC_WD'(2);
    localparam logic [DEC_WD-1:0] ADDR_VER_L   = DEC_WD'(3);
    localparam logic [DEC_WD-1:0] ADDR_TEST    = DEC_WD'(4);
    localparam logic [DEC_WD-1:0] ADDR_SCRATCH = DEC_WD'(5);
    localparam logic [DEC_WD-1:0] ADDR_RDCNT   = DEC_WD'(6);
`ifdef FIX_UPTIME_CNT_EN
    localparam logic [DEC_WD-1:0] ADDR_UP_3    = DEC_WD'(8);
    localparam logic [DEC_WD-1:0] ADDR_UP_2    = DEC_WD'(9);
    localparam logic [DEC_WD-1:0] ADDR_UP_1    = DEC_WD'(10);
    localparam logic [DEC_WD-1:0] ADDR_UP_0    = DEC_WD'(11);
`endif

    logic [DEC_WD-1:0]       decAddr;
    logic                    readStart;
    logic                    hit;
    logic [SHORT_REG_WD-1:0] word;

    logic                    rdEnPrev_q;
    logic                    sel_q,      sel_d;
    logic [SHORT_REG_WD-1:0] rdData_q,   rdData_d;
    logic [SHORT_REG_WD-1:0] scratch_q,  scratch_d;
    logic [SHORT_REG_WD-1:0] rdCnt_q,    rdCnt_d;

`ifdef FIX_UPTIME_CNT_EN
    logic [LONG_REG_WD-1:0]  uptime_q,   uptime_d;
    logic [LONG_REG_WD-1:0]  snap_q,     snap_d;

    // Read mux uses snap_d so a 0x08 read start returns the value captured in that same cycle.
    always_comb begin
        uptime_d = uptime_q + LONG_REG_WD'(1);
        snap_d   = snap_q;
        if (readStart && decAddr == ADDR_UP_3) begin
            snap_d = uptime_q;
        end
    end

    always_ff @(posedge clk_sample) begin
        if (reset_sample) begin
            uptime_q <= '0;
            snap_q   <= '0;
        end else begin
            uptime_q <= uptime_d;
            snap_q   <= snap_d;
        end
    end
`endif

    always_comb begin
        decAddr   = bus.iv_addr[DEC_WD-1:0];
        readStart = bus.i_rd_en && !rdEnPrev_q;
        hit       = 1'b1;
        word      = '0;
        case (decAddr)
            ADDR_VENDOR:  word = VENDOR_ID;
            ADDR_PRODUCT: word = PRODUCT_ID;
            ADDR_VER_H:   word = FPGA_VERSION_H;
            ADDR_VER_L:   word = FPGA_VERSION_L;
            ADDR_TEST:    word = TEST_VERSION;
            ADDR_SCRATCH: word = scratch_q;
            ADDR_RDCNT:   word = rdCnt_q;
`ifdef FIX_UPTIME_CNT_EN
            ADDR_UP_3:    word = snap_d[LONG_REG_WD-1                  -: SHORT_REG_WD];
            ADDR_UP_2:    word = snap_d[LONG_REG_WD-1-SHORT_REG_WD     -: SHORT_REG_WD];
            ADDR_UP_1:    word = snap_d[LONG_REG_WD-1-2*SHORT_REG_WD   -: SHORT_REG_WD];
            ADDR_UP_0:    word = snap_d[LONG_REG_WD-1-3*SHORT_REG_WD   -: SHORT_REG_WD];
`endif
            default:      hit  = 1'b0;
        endcase
    end

    // A clear by write takes priority over a same-cycle read-start increment.
    always_comb begin
        sel_d     = bus.i_rd_en && hit;
        rdData_d  = sel_d ? word : '0;
        scratch_d = scratch_q;
        if (bus.i_wr_en && decAddr == ADDR_SCRATCH) begin
            scratch_d = bus.iv_wr_data;
        end
        rdCnt_d = rdCnt_q;
        if (bus.i_wr_en && decAddr == ADDR_RDCNT) begin
            rdCnt_d = '0;
        end else if (readStart && hit && rdCnt_q != '1) begin
            rdCnt_d = rdCnt_q + SHORT_REG_WD'(1);
        end
    end

    always_ff @(posedge clk_sample) begin
        if (reset_sample) begin
            rdEnPrev_q <= 1'b0;
            sel_q      <= 1'b0;
            rdData_q   <= '0;
            scratch_q  <= '0;
            rdCnt_q    <= '0;
        end else begin
            rdEnPrev_q <= bus.i_rd_en;
            sel_q      <= sel_d;
            rdData_q   <= rdData_d;
            scratch_q  <= scratch_d;
            rdCnt_q    <= rdCnt_d;
        end
    end

    assign bus.o_fix_sel      = sel_q;
    assign bus.ov_fix_rd_data = rdData_q;

endmodule
